// File: rtl/pc_gen_pkg.sv
// Shared constants and types for the fetch-address generator (pc_gen).
package pc_gen_pkg;
  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic Branch      = 1'b1;
  localparam logic NoStop      = 1'b0;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEFAULT_INCR         = 4;
  localparam int          PC_STALL_BIT         = 0;

  // One action per edge, listed highest priority first.
  typedef enum logic [2:0] {
    ACT_FLUSH,
    ACT_STALL,
    ACT_PEND,
    ACT_BRANCH,
    ACT_SEQ
  } pc_act_e;
endpackage

// File: rtl/pc_pending_buf.sv
// One-entry buffer holding a branch that resolved while the PC stage was stalled.
module pc_pending_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capture,
  input  logic              consume,
  input  logic [ADDR_W-1:0] target_in,
  output logic              valid,
  output logic [ADDR_W-1:0] target
);
  import pc_gen_pkg::*;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      // A later branch in the same stall window overwrites the earlier one.
      valid  <= 1'b1;
      target <= target_in;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pc_gen.sv
// IF-stage fetch-address generator with flush redirect and pending-branch buffer.
// Define PC_MISALIGN_CHK_EN to add the registered misalign_o output.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
  parameter int              INCR         = DEFAULT_INCR,
  parameter int              STALL_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               branch_pending_o
`ifdef PC_MISALIGN_CHK_EN
  ,
  output logic               misalign_o
`endif
);

  pc_act_e           act;
  logic [ADDR_W-1:0] pc_nxt;
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_tgt;
  logic              stall_pc;
  logic              unused_stall;

  assign stall_pc     = stall[PC_STALL_BIT];
  assign unused_stall = ^stall;

  always_comb begin
    act = ACT_SEQ;
    if (flush)                     act = ACT_FLUSH;
    else if (stall_pc != NoStop)   act = ACT_STALL;
    else if (pend_vld)             act = ACT_PEND;
    else if (branch_flag_i == Branch) act = ACT_BRANCH;
  end

  always_comb begin
    pc_nxt = pc + ADDR_W'(INCR);
    if (ce == ChipDisable) pc_nxt = RESET_VECTOR;
    else begin
      case (act)
        ACT_FLUSH:  pc_nxt = new_pc;
        ACT_STALL:  pc_nxt = pc;
        ACT_PEND:   pc_nxt = pend_tgt;
        ACT_BRANCH: pc_nxt = branch_target_address_i;
        default:    pc_nxt = pc + ADDR_W'(INCR);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      ce <= ChipDisable;
      pc <= RESET_VECTOR;
    end else begin
      ce <= ChipEnable;
      pc <= pc_nxt;
    end
  end

  pc_pending_buf #(.ADDR_W(ADDR_W)) u_pend (
    .clk       (clk),
    .rst       (rst),
    .clear     (ce && act == ACT_FLUSH),
    .capture   (ce && act == ACT_STALL && branch_flag_i == Branch),
    .consume   (ce && act == ACT_PEND),
    .target_in (branch_target_address_i),
    .valid     (pend_vld),
    .target    (pend_tgt)
  );

  assign branch_pending_o = pend_vld;

`ifdef PC_MISALIGN_CHK_EN
  // Tracks the alignment of every pc load; a stall is not a load, so it holds.
  always_ff @(posedge clk) begin
    if (rst == RstEnable)
      misalign_o <= 1'b0;
    else if (ce == ChipDisable || act != ACT_STALL)
      misalign_o <= |pc_nxt[1:0];
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (RESET_VECTOR = BFC0_0000).
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] pc;
  logic        ce;
  logic        branch_pending_o;
`ifdef PC_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  int npass = 0;
  int ntot  = 0;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  always #5 clk = ~clk;

  pc_gen #(.ADDR_W(32), .RESET_VECTOR(RV), .INCR(4), .STALL_W(6)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .pc                      (pc),
    .ce                      (ce),
    .branch_pending_o        (branch_pending_o)
`ifdef PC_MISALIGN_CHK_EN
    ,
    .misalign_o              (misalign_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] st, input logic br, input logic [31:0] tgt);
    stall = st; branch_flag_i = br; branch_target_address_i = tgt;
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] epc, input logic epend);
    chk({tag, "_pc"}, pc, epc);
    chk({tag, "_pend"}, {31'd0, branch_pending_o}, {31'd0, epend});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; new_pc = '0;
    drive(6'd0, 1'b0, 32'd0);
    step(); step();
    chk("rst_ce", {31'd0, ce}, 32'd0);
    chk_pc("rst", RV, 1'b0);

    // Reset release: ce rises one edge later, RESET_VECTOR presented first.
    rst = 1'b0;
    step(); chk("rel_ce", {31'd0, ce}, 32'd1); chk("rel_pc0", pc, RV);
    step(); chk("rel_pc1", pc, 32'hBFC0_0004);
    step(); chk("rel_pc2", pc, 32'hBFC0_0008);

    // Unstalled branch 0x10 then 0x80, then sequential.
    drive(6'd0, 1'b1, 32'h10);  step(); chk("br_10", pc, 32'h10);
    drive(6'd0, 1'b1, 32'h80);  step(); chk("br_80", pc, 32'h80);
    drive(6'd0, 1'b0, 32'h0);   step(); chk("br_84", pc, 32'h84);

    // Three-cycle stall, branch on the second stall cycle.
    drive(6'd1, 1'b0, 32'h0);   step(); chk_pc("st1", 32'h84, 1'b0);
    drive(6'd1, 1'b1, 32'h200); step(); chk_pc("st2", 32'h84, 1'b1);
    drive(6'd1, 1'b0, 32'h0);   step(); chk_pc("st3", 32'h84, 1'b1);
    // Pending branch wins over a fresh branch on the release edge.
    drive(6'd0, 1'b1, 32'h300); step(); chk_pc("st_rel", 32'h200, 1'b0);
    drive(6'd0, 1'b0, 32'h0);   step(); chk("st_seq", pc, 32'h204);

    // Later branch in the same stall overwrites the pending target.
    drive(6'd1, 1'b1, 32'h400); step();
    drive(6'd1, 1'b1, 32'h500); step(); chk_pc("ow_hold", 32'h204, 1'b1);
    drive(6'd0, 1'b0, 32'h0);   step(); chk_pc("ow_rel", 32'h500, 1'b0);

    // Flush beats stall and drops the pending branch.
    drive(6'd1, 1'b1, 32'h600); step(); chk_pc("fl_set", 32'h500, 1'b1);
    drive(6'd1, 1'b1, 32'h700); flush = 1'b1; new_pc = 32'h180;
    step(); chk_pc("fl", 32'h180, 1'b0);
    flush = 1'b0; drive(6'd0, 1'b0, 32'h0);
    step(); chk_pc("fl_seq", 32'h184, 1'b0);

    // Upper stall bits do not hold the PC.
    drive(6'b111110, 1'b0, 32'h0); step(); chk("st_hi", pc, 32'h188);

    // Wrap at the top of the address space.
    drive(6'd0, 1'b1, 32'hFFFF_FFFC); step(); chk("wrap_pre", pc, 32'hFFFF_FFFC);
    drive(6'd0, 1'b0, 32'h0);         step(); chk("wrap", pc, 32'h0);

`ifdef PC_MISALIGN_CHK_EN
    drive(6'd0, 1'b1, 32'h102); step();
    chk("mis_pc", pc, 32'h102); chk("mis_set", {31'd0, misalign_o}, 32'd1);
    drive(6'd1, 1'b0, 32'h0);   step(); chk("mis_hold", {31'd0, misalign_o}, 32'd1);
    drive(6'd0, 1'b1, 32'h100); step();
    chk("mis_pc2", pc, 32'h100); chk("mis_clr", {31'd0, misalign_o}, 32'd0);
`endif

    // Mid-run reset discards a pending branch and restarts with the ce delay.
    drive(6'd1, 1'b1, 32'h900); step(); chk("mr_pend", {31'd0, branch_pending_o}, 32'd1);
    drive(6'd0, 1'b0, 32'h0); rst = 1'b1;
    step(); chk("mr_ce", {31'd0, ce}, 32'd0); chk_pc("mr", RV, 1'b0);
    rst = 1'b0;
    step(); chk("mr_ce1", {31'd0, ce}, 32'd1); chk_pc("mr_rel", RV, 1'b0);
    step(); chk("mr_seq", pc, 32'hBFC0_0004);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-address generator; successor to the single-width PC register; sits at the head of the IF stage.
- Drives the instruction-memory address and chip enable.
- Adds over the previous generation: a configurable reset vector, an exception/flush redirect with priority over stall, and a one-entry pending-branch buffer so a branch resolved during a stall is not lost.

Parameters:
- ADDR_W, 32, PC and target width in bits.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- INCR, 4, sequential byte increment per fetch.
- STALL_W, 6, width of the stall vector from ctrl; bit 0 is the PC stage.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- stall  input  STALL_W  stall vector from ctrl; stall[0]=1 holds the PC
- flush  input  1  exception/eret redirect; overrides stall
- new_pc  input  ADDR_W  redirect target, sampled when flush=1
- branch_flag_i  input  1  branch taken, from ID
- branch_target_address_i  input  ADDR_W  branch target, from ID
- pc  output  ADDR_W  current fetch address
- ce  output  1  instruction-memory chip enable
- branch_pending_o  output  1  a captured branch is waiting to be applied

Behaviour:
- Reset (rst=1 at posedge): ce<=0, pc<=RESET_VECTOR, pending valid<=0, pending target<=0, misalign<=0.
- ce rises on the first posedge with rst=0. pc tracks ce, not rst: while ce=0, pc<=RESET_VECTOR. The first ce=1 cycle therefore presents RESET_VECTOR; the first increment happens on the next edge.
- When ce=1, each posedge applies exactly one action, highest priority first:
  1. flush=1: pc<=new_pc; pending valid<=0. Stall and branch inputs are ignored.
  2. stall[0]=1: pc holds. If branch_flag_i=1, pending valid<=1 and pending target<=branch_target_address_i; a later branch during the same stall overwrites it.
  3. pending valid=1: pc<=pending target; pending valid<=0; branch_flag_i is ignored this cycle.
  4. branch_flag_i=1: pc<=branch_target_address_i.
  5. Otherwise: pc<=pc+INCR, truncated to ADDR_W (wraps modulo 2^ADDR_W, no flag).
- branch_pending_o equals pending valid (registered, no combinational path).
- stall[STALL_W-1:1] are unused by this block.
- rst asserted mid-operation discards pending state and restarts from RESET_VECTOR with the one-cycle ce delay.
- Latency: one edge from any input to pc; no combinational input-to-output path.

Optional Feature:
- Macro PC_MISALIGN_CHK_EN.
- Defined: adds output misalign_o (1 bit, registered). It is set on the edge that loads pc with a value whose low 2 bits are nonzero, from any source. It is cleared on the edge that loads an aligned pc. It holds during stall. ce and pc are unaffected; ID/EX raises AdEL from misalign_o.
- Undefined: no port, no logic; any value is loaded silently.

Decomposition:
- Shared package/defines: RstEnable, ChipEnable/ChipDisable, Branch, NoStop, default RESET_VECTOR, default INCR, the stall-vector bit index for the PC stage.
- One natural sub-module, pc_pending_buf: holds valid and target.
  - capture: stall & branch
  - consume: !stall & valid
  - clear: flush or rst

Test Plan:
- Reset release, RESET_VECTOR=32'hBFC0_0000, no stall: ce 0→1 one edge after rst falls; pc sequence BFC00000, BFC00004, BFC00008.
- Branch unstalled at pc=0x10, target 0x80: next pc=0x80, then 0x84.
- stall[0]=1 for 3 cycles with branch_flag_i pulsed on stall cycle 2 (target 0x200): pc held, branch_pending_o=1; first unstalled edge pc=0x200, pending cleared.
- flush with stall[0]=1 and pending set, new_pc=0x180: pc=0x180, branch_pending_o=0, pending target never applied.
- pc=32'hFFFF_FFFC, no stall: next pc=0x0000_0000.
- With PC_MISALIGN_CHK_EN, branch to 0x102: misalign_o=1 the edge pc=0x102 loads; branch to 0x100 clears it.
